// File: rtl/reg_file_sb_pkg.sv
// Shared defaults, zero-register constant and packed-port slicing macro for reg_file_sb.
// Optional write-back bypass is enabled with the macro REG_FILE_BYPASS_EN.
`ifndef REG_FILE_SB_PKG_SV
`define REG_FILE_SB_PKG_SV

`define RF_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package reg_file_sb_pkg;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned ADDR_WIDTH_DEF = 5;
    localparam int unsigned NUM_RD_DEF     = 2;
    localparam int unsigned REG_ZERO       = 0;
endpackage

`endif

// File: rtl/reg_file_rd_port.sv
// One combinational read port: stored data/busy lookup, r0 forced to zero.
// With REG_FILE_BYPASS_EN a same-cycle write-back is forwarded to the port.
module reg_file_rd_port
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    input  logic [DATA_WIDTH-1:0] i_mem [2**ADDR_WIDTH],
    input  logic [2**ADDR_WIDTH-1:0] i_busy,
`ifdef REG_FILE_BYPASS_EN
    input  logic                  i_byp_en,
    input  logic [ADDR_WIDTH-1:0] i_byp_addr,
    input  logic [DATA_WIDTH-1:0] i_byp_data,
    input  logic                  i_byp_busy,
`endif
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rbusy
);
    localparam logic [ADDR_WIDTH-1:0] L_ZERO = ADDR_WIDTH'(REG_ZERO);

    always_comb begin
        o_rdata = '0;
        o_rbusy = 1'b0;
        if (i_raddr != L_ZERO) begin
            o_rdata = i_mem[i_raddr];
            o_rbusy = i_busy[i_raddr];
`ifdef REG_FILE_BYPASS_EN
            // i_byp_en already excludes r0, so r0 never forwards
            if (i_byp_en && (i_byp_addr == i_raddr)) begin
                o_rdata = i_byp_data;
                o_rbusy = i_byp_busy;
            end
`endif
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Register file with NUM_RD read ports, one write port, busy scoreboard and busy counter.
// Optional write-back forwarding: define REG_FILE_BYPASS_EN.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned NUM_RD     = NUM_RD_DEF
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    input  logic                         flush,
    output logic [ADDR_WIDTH:0]          busy_cnt
);
    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] L_ZERO = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_busy;
    logic [CNT_W-1:0]      r_cnt;

    logic             w_wr;
    logic             w_al;
    logic             w_same;
    logic             w_set;
    logic             w_clr;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_wr   = wen && (waddr != L_ZERO);
    assign w_al   = alloc_en && (alloc_addr != L_ZERO);
    assign w_same = w_al && (alloc_addr == waddr);

    // Counter tracks only real transitions; a clear is cancelled by a same-address alloc
    assign w_set = w_al && !r_busy[alloc_addr];
    assign w_clr = w_wr && r_busy[waddr] && !w_same;

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr) w_busy_nxt[waddr] = 1'b0;
        if (w_al) w_busy_nxt[alloc_addr] = 1'b1;
        if (flush) w_busy_nxt = '0;
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_set) w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
        if (w_clr) w_cnt_nxt = w_cnt_nxt - CNT_W'(1);
        if (flush) w_cnt_nxt = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) r_mem[waddr] <= wdata;
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy_cnt = r_cnt;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        reg_file_rd_port #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_rd (
            .i_raddr    (`RF_SLICE(raddr, g, ADDR_WIDTH)),
            .i_mem      (r_mem),
            .i_busy     (r_busy),
`ifdef REG_FILE_BYPASS_EN
            .i_byp_en   (w_wr),
            .i_byp_addr (waddr),
            .i_byp_data (wdata),
            .i_byp_busy (w_same),
`endif
            .o_rdata    (`RF_SLICE(rdata, g, DATA_WIDTH)),
            .o_rbusy    (rbusy[g])
        );
    end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised successor to the 32x32 register file. It has NUM_RD combinational read ports and one synchronous write port, and adds asynchronous clear of the whole array plus a per-register busy scoreboard. Busy bits are set at issue (alloc) and cleared at write-back. The block sits between decode/issue and write-back of the multi-cycle CPU, so the issue stage can stall on RAW hazards.

Parameters:
DATA_WIDTH, 32, width of each register
ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
NUM_RD, 2, number of independent read ports (1..4)

Ports:
clk  input  1  clock, all state updates on rising edge
resetn  input  1  asynchronous active-low reset
raddr  input  NUM_RD*ADDR_WIDTH  packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NUM_RD*DATA_WIDTH  packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
rbusy  output  NUM_RD  port i target register has a pending write
wen  input  1  write-back enable
waddr  input  ADDR_WIDTH  write-back address
wdata  input  DATA_WIDTH  write-back data
alloc_en  input  1  issue marks alloc_addr busy
alloc_addr  input  ADDR_WIDTH  destination register being issued
flush  input  1  synchronous clear of all busy bits (pipeline flush); data kept
busy_cnt  output  ADDR_WIDTH+1  number of busy registers, registered

Behaviour:
- Reset is asynchronous and active-low. While resetn=0, all registers = 0, all busy bits = 0 and busy_cnt = 0. rdata therefore reads 0 and rbusy reads 0 during reset and after release.
- Read ports:
  - Combinational, zero latency.
  - raddr=0 gives rdata=0 and rbusy=0, always.
  - Otherwise rdata = array[raddr] and rbusy = busy[raddr].
- Write:
  - On a rising edge with wen=1 and waddr!=0, array[waddr] <= wdata and busy[waddr] <= 0.
  - wen with waddr=0 is ignored. Register 0 stays 0 permanently.
- Alloc:
  - On a rising edge with alloc_en=1 and alloc_addr!=0, busy[alloc_addr] <= 1.
  - Alloc on an already-busy register is legal (WAW). The bit stays 1 and busy_cnt is unchanged.
  - alloc_addr=0 is ignored.
- Priority per register in one cycle: flush > alloc > write-clear.
  - wen and alloc_en to the same nonzero address in one cycle: data is written AND the busy bit ends at 1, because a new producer has been issued.
  - flush=1: all busy bits <= 0 that cycle, even with a simultaneous alloc. A simultaneous wen still writes data.
- busy_cnt:
  - Updated on the same edge as the busy bits, so it always equals popcount(busy) of the current state.
  - Maintained incrementally: +1 on a 0->1 transition, -1 on a 1->0 transition, net of both in the same cycle. Flush sets it to 0.
  - Range is 0..2**ADDR_WIDTH-1, so it never overflows.
- Reset asserted mid-operation overrides everything immediately; no edge is required.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: a read port whose raddr equals the current-cycle waddr (wen=1, waddr!=0) returns wdata combinationally and rbusy=0 for that port, unless alloc_en targets the same address that cycle (then rbusy=1, rdata still = wdata). This gives write-back-to-read forwarding with zero bubble.
- Undefined: reads return only the stored value. New data is visible the cycle after the write edge, and rbusy reflects only stored busy bits.

Decomposition:
- Shared package/header: DATA_WIDTH, ADDR_WIDTH and NUM_RD defaults; the REG_ZERO address constant; packed-port slicing macros.
- One sub-module, reg_file_rd_port: a single read port (address in, array/busy/bypass in, rdata/rbusy out), instantiated NUM_RD times by generate.
- The array, scoreboard and counter stay in the top module.

Test Plan:
- Reset: drive resetn=0 mid-run after writing 0x12345678 to r5 -> raddr=5 immediately reads 0, rbusy=0, busy_cnt=0.
- Write/read: write 0xDEADBEEF to r7, then 0xFFFFFFFF to r0 -> port0 raddr=7 reads 0xDEADBEEF; port1 raddr=0 reads 0.
- Scoreboard: alloc r3 -> rbusy=1, busy_cnt=1; later wen r3=0xA5 -> rbusy=0, busy_cnt=0, rdata=0xA5.
- Same-cycle alloc+write r9 (r9 busy beforehand): data=0x55 stored, rbusy stays 1, busy_cnt unchanged. Alloc r9 twice -> busy_cnt counts 1.
- Flush: alloc r1, r2, r31; then flush with simultaneous alloc r4 -> all rbusy=0, busy_cnt=0. The simultaneous wen r2=0x77 is still written.
- Bypass (REG_FILE_BYPASS_EN): wen r6=0xCAFE with raddr=6 in the same cycle -> rdata=0xCAFE before the edge. Without the macro -> old value before the edge, 0xCAFE after.
